// File: rtl/branch_target_predictor_pkg.sv
// Shared constants and helpers for the fetch-side branch target predictor.
//   WORD_SIZE      : default address/data width
//   BP_*           : 2-bit saturating counter states (strongly/weakly not-taken/taken)
//   bp_sat_step()  : one training step of a 2-bit saturating counter
package branch_target_predictor_pkg;

    localparam int WORD_SIZE = 16;

    localparam logic [1:0] BP_SNT       = 2'b00;
    localparam logic [1:0] BP_WNT       = 2'b01;
    localparam logic [1:0] BP_WT        = 2'b10;
    localparam logic [1:0] BP_ST        = 2'b11;
    localparam logic [1:0] BP_CTR_RESET = BP_WNT;
    localparam logic [1:0] BP_CTR_ALLOC = BP_WT;

    function automatic logic [1:0] bp_sat_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != BP_ST)
            nxt = ctr + 2'b01;
        else if (!taken && ctr != BP_SNT)
            nxt = ctr - 2'b01;
        return nxt;
    endfunction

endpackage

// File: rtl/branch_target_predictor_bp_sat_counter.sv
// 2-bit saturating counter next-state logic (pure combinational).
//   ctr_i   : current counter value
//   taken_i : resolved outcome (1 = increment, 0 = decrement)
//   ctr_o   : next counter value, clamped to [BP_SNT, BP_ST]
module bp_sat_counter
    import branch_target_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    assign ctr_o = bp_sat_step(ctr_i, taken_i);

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB next-PC predictor with 2-bit saturating counters.
//   clk, reset_n            : clock / async active-low reset
//   if_pc                   : fetch PC looked up combinationally
//   pred_taken/pred_next_pc : prediction for if_pc
//   update_*                : one resolved jump (ID) or branch (EX) per cycle
//   mispredict              : resolved outcome disagrees with the carried prediction
//   num_branch(_miss)       : conditional branch statistics, wrap mod 2**WORD_SIZE
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int WORD_SIZE  = branch_target_predictor_pkg::WORD_SIZE,
    parameter int INDEX_BITS = 4,
    parameter bit ENABLE     = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic                 pred_taken,
    output logic [WORD_SIZE-1:0] pred_next_pc,
    input  logic                 update_valid,
    input  logic [WORD_SIZE-1:0] update_pc,
    input  logic                 update_is_branch,
    input  logic                 update_taken,
    input  logic [WORD_SIZE-1:0] update_target,
    input  logic                 update_pred_taken,
    input  logic [WORD_SIZE-1:0] update_pred_target,
    output logic                 mispredict,
    output logic [WORD_SIZE-1:0] num_branch,
    output logic [WORD_SIZE-1:0] num_branch_miss
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - INDEX_BITS;

    // Flat register arrays so reset can clear every valid bit at once.
    logic                 valid_q   [ENTRIES];
    logic [TAG_W-1:0]     tag_q     [ENTRIES];
    logic [WORD_SIZE-1:0] target_q  [ENTRIES];
    logic                 is_jump_q [ENTRIES];
    logic [1:0]           ctr_q     [ENTRIES];

    logic [WORD_SIZE-1:0] num_branch_q, num_branch_d;
    logic [WORD_SIZE-1:0] num_miss_q,   num_miss_d;

    // ---------------- lookup ----------------
    logic [INDEX_BITS-1:0] l_idx;
    logic                  l_hit;

    assign l_idx = if_pc[INDEX_BITS-1:0];
    assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == if_pc[WORD_SIZE-1:INDEX_BITS]);

    assign pred_taken   = ENABLE && reset_n && l_hit && (is_jump_q[l_idx] || ctr_q[l_idx][1]);
    assign pred_next_pc = pred_taken ? target_q[l_idx] : if_pc + WORD_SIZE'(1);

    // Target compare only matters when the instruction was actually taken.
    assign mispredict = reset_n && update_valid &&
                        ((update_taken != update_pred_taken) ||
                         (update_taken && (update_target != update_pred_target)));

    // ---------------- training ----------------
    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_W-1:0]      u_tag;
    logic                  u_hit;
    logic [1:0]            ctr_step;

    assign u_idx = update_pc[INDEX_BITS-1:0];
    assign u_tag = update_pc[WORD_SIZE-1:INDEX_BITS];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    bp_sat_counter u_ctr (
        .ctr_i   (ctr_q[u_idx]),
        .taken_i (update_taken),
        .ctr_o   (ctr_step)
    );

    logic                 wr_en;
    logic [WORD_SIZE-1:0] wr_target;
    logic                 wr_jump;
    logic [1:0]           wr_ctr;

    always_comb begin
        wr_en     = 1'b0;
        wr_target = target_q[u_idx];
        wr_jump   = is_jump_q[u_idx];
        wr_ctr    = ctr_q[u_idx];
        if (ENABLE && update_valid) begin
            if (u_hit) begin
                // Hit keeps the entry valid; only counter and (if taken) target move.
                wr_en  = 1'b1;
                wr_ctr = ctr_step;
                if (update_taken)
                    wr_target = update_target;
            end else if (update_taken) begin
                // Miss-taken allocates, evicting any alias at this index.
                wr_en     = 1'b1;
                wr_target = update_target;
                wr_jump   = !update_is_branch;
                wr_ctr    = BP_CTR_ALLOC;
            end
        end
    end

    always_comb begin
        num_branch_d = num_branch_q;
        num_miss_d   = num_miss_q;
        if (update_valid && update_is_branch) begin
            num_branch_d = num_branch_q + WORD_SIZE'(1);
            if (mispredict)
                num_miss_d = num_miss_q + WORD_SIZE'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                tag_q[i]     <= '0;
                target_q[i]  <= '0;
                is_jump_q[i] <= 1'b0;
                ctr_q[i]     <= BP_CTR_RESET;
            end
            num_branch_q <= '0;
            num_miss_q   <= '0;
        end else begin
            if (wr_en) begin
                valid_q[u_idx]   <= 1'b1;
                tag_q[u_idx]     <= u_tag;
                target_q[u_idx]  <= wr_target;
                is_jump_q[u_idx] <= wr_jump;
                ctr_q[u_idx]     <= wr_ctr;
            end
            num_branch_q <= num_branch_d;
            num_miss_q   <= num_miss_d;
        end
    end

    assign num_branch      = num_branch_q;
    assign num_branch_miss = num_miss_q;

endmodule
